// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: types and helpers shared by the data-memory controller and its
// byte-lane storage array.
//   mem_size_t   - access size encoding (byte/half/word); 3 is illegal.
//   dmem_state_t - controller FSM states.
//   dmem_req_t   - captured request. The size field is kept raw so the
//                  illegal encoding survives capture and can be faulted.
//   align_load   - extracts and extends a byte/half/word from a read word.
//   access_bytes - number of bytes touched by an access of a given size.
package rv_mem_pkg;

  // Widest request address the captured-request struct can carry.
  localparam int REQ_ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic [REQ_ADDR_MAX_W-1:0] addr;
    logic                      wr_en;
    logic [1:0]                size;
    logic                      is_signed;
    logic [31:0]               wr_data;
  } dmem_req_t;

  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [1:0]  offset,
                                             input logic [1:0]  size,
                                             input logic        is_signed);
    logic [31:0] shifted;
    shifted = word >> {offset, 3'b000};
    case (size)
      SIZE_B:  align_load = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SIZE_H:  align_load = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: align_load = shifted;
    endcase
  endfunction

  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  access_bytes = 3'd1;
      SIZE_H:  access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rv_dmem_array.sv
// rv_dmem_array: word-organised, byte-lane-writable storage.
//   clk      - clock; write and read both happen on the rising edge.
//   word_idx - word index shared by the write and read port.
//   rd_en    - registers the addressed word into rd_data.
//   wr_be    - per-lane write enables, lane 0 = bits [7:0].
//   wr_data  - lane-steered write data.
//   rd_data  - registered read word (read-before-write on a shared edge).
// Contents are never reset.
module rv_dmem_array #(
  parameter int WORDS = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] word_idx,
  input  logic             rd_en,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] rd_lane_reg;

      always_ff @(posedge clk) begin
        if (wr_be[gi]) begin
          lane_mem[word_idx] <= wr_data[8*gi +: 8];
        end
        if (rd_en) begin
          rd_lane_reg <= lane_mem[word_idx];
        end
      end

      assign rd_data[8*gi +: 8] = rd_lane_reg;
    end
  endgenerate

endmodule

// File: rtl/rv_dmem_ctrl.sv
// rv_dmem_ctrl: data-memory controller with valid/ready request and response
// channels, configurable wait states and byte/half/word sizing.
//   clk           - clock.
//   rst           - asynchronous, active-low reset.
//   req_valid/req_ready - request handshake; accepted only in IDLE.
//   req_addr, req_wr_en, req_size, req_is_signed, req_wr_data - request fields.
//   rsp_valid/rsp_ready - response handshake; response held until rsp_ready.
//   rsp_rd_data   - extended load data; 0 for stores and faults.
//   rsp_fault     - misaligned, out-of-range or illegal-size access.
// One transaction is outstanding at a time.
module rv_dmem_ctrl
  import rv_mem_pkg::*;
#(
  parameter int DMEM_SIZE_BYTES = 1024,
  parameter int ADDR_W          = 32,
  parameter int WAIT_CYCLES     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wr_en,
  input  logic [1:0]        req_size,
  input  logic              req_is_signed,
  input  logic [31:0]       req_wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rd_data,
  output logic              rsp_fault
);

  localparam int BYTE_AW    = $clog2(DMEM_SIZE_BYTES);
  localparam int WORDS      = DMEM_SIZE_BYTES / 4;
  localparam int IDX_W      = (BYTE_AW > 2) ? BYTE_AW - 2 : 1;
  localparam int CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int WAIT_LOAD  = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam int ADDR_SUM_W = REQ_ADDR_MAX_W + 1;

  dmem_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  dmem_req_t        req_reg;
  logic             fault_reg;

  dmem_req_t        live_req;
  dmem_req_t        acc_req;
  logic             enter_resp;
  logic             acc_fault;
  logic [ADDR_SUM_W-1:0] acc_end;
  logic [1:0]       acc_off;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic [3:0]       arr_be;
  logic [IDX_W-1:0] arr_idx;
  logic [31:0]      rd_word;

  always_comb begin
    live_req           = '0;
    live_req.addr      = REQ_ADDR_MAX_W'(req_addr);
    live_req.wr_en     = req_wr_en;
    live_req.size      = req_size;
    live_req.is_signed = req_is_signed;
    live_req.wr_data   = req_wr_data;
  end

  // The array is accessed on the edge that enters RESP. With zero wait states
  // that is the acceptance edge itself, before the request register is loaded,
  // so in IDLE the live inputs drive the access instead.
  assign acc_req = (state_reg == IDLE) ? live_req : req_reg;
  assign acc_off = acc_req.addr[1:0];

  // Range check is done one bit wider than the address so that addresses near
  // the top of the address space cannot wrap around and look in range.
  assign acc_end = {1'b0, acc_req.addr} + ADDR_SUM_W'(access_bytes(acc_req.size));

  always_comb begin
    acc_fault = 1'b0;
    if (acc_req.size == 2'd3) begin
      acc_fault = 1'b1;
    end
    if (acc_req.size == SIZE_H && acc_off[0]) begin
      acc_fault = 1'b1;
    end
    if (acc_req.size == SIZE_W && acc_off != 2'd0) begin
      acc_fault = 1'b1;
    end
    if (acc_end > ADDR_SUM_W'(DMEM_SIZE_BYTES)) begin
      acc_fault = 1'b1;
    end
  end

  // Right-aligned store data is replicated across lanes; the enables pick
  // which copies land in the array.
  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = acc_req.wr_data;
    case (acc_req.size)
      SIZE_B: begin
        lane_be    = 4'b0001 << acc_off;
        lane_wdata = {4{acc_req.wr_data[7:0]}};
      end
      SIZE_H: begin
        lane_be    = 4'b0011 << acc_off;
        lane_wdata = {2{acc_req.wr_data[15:0]}};
      end
      SIZE_W: begin
        lane_be    = 4'b1111;
        lane_wdata = acc_req.wr_data;
      end
      default: begin
        lane_be    = 4'b0000;
        lane_wdata = acc_req.wr_data;
      end
    endcase
  end

  assign arr_be = (enter_resp && acc_req.wr_en && !acc_fault) ? lane_be : 4'b0000;

  generate
    if (BYTE_AW > 2) begin : g_idx
      assign arr_idx = acc_req.addr[BYTE_AW-1:2];
    end else begin : g_idx_single
      assign arr_idx = '0;
    end
  endgenerate

  rv_dmem_array #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .word_idx (arr_idx),
    .rd_en    (enter_resp),
    .wr_be    (arr_be),
    .wr_data  (lane_wdata),
    .rd_data  (rd_word)
  );

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      req_reg   <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        req_reg <= live_req;
        cnt_reg <= CNT_W'(WAIT_LOAD);
      end else if (state_reg == WAIT && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (enter_resp) begin
        fault_reg <= acc_fault;
      end
    end
  end

  // Outputs are gated by RESP so they read 0 out of reset even though the
  // array read register itself is never reset.
  assign rsp_fault   = (state_reg == RESP) && fault_reg;
  assign rsp_rd_data = (state_reg == RESP && !req_reg.wr_en && !fault_reg)
                     ? align_load(rd_word, req_reg.addr[1:0], req_reg.size, req_reg.is_signed)
                     : 32'h0;

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Bench for rv_dmem_ctrl: three instances with 1, 0 and 3 wait states.
// Expected responses are pushed to a queue when a request is driven and
// popped when the addressed instance raises rsp_valid.
module tb_rv_dmem_ctrl;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr [3];
  logic        req_wr_en [3];
  logic [1:0]  req_size [3];
  logic        req_is_signed [3];
  logic [31:0] req_wr_data [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rd_data [3];
  logic        rsp_fault [3];

  exp_t        exp_q [$];
  logic [7:0]  mem_model [1024];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      rv_dmem_ctrl #(
        .DMEM_SIZE_BYTES (1024),
        .ADDR_W          (32),
        .WAIT_CYCLES     ((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
      ) u_dut (
        .clk           (clk),
        .rst           (rst[gi]),
        .req_valid     (req_valid[gi]),
        .req_ready     (req_ready[gi]),
        .req_addr      (req_addr[gi]),
        .req_wr_en     (req_wr_en[gi]),
        .req_size      (req_size[gi]),
        .req_is_signed (req_is_signed[gi]),
        .req_wr_data   (req_wr_data[gi]),
        .rsp_valid     (rsp_valid[gi]),
        .rsp_ready     (rsp_ready[gi]),
        .rsp_rd_data   (rsp_rd_data[gi]),
        .rsp_fault     (rsp_fault[gi])
      );
    end
  endgenerate

  function automatic int wait_of(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 0 : 3);
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
    logic [7:0]  b0;
    logic [15:0] h;
    b0 = mem_model[a[9:0]];
    h  = {mem_model[a[9:0] + 10'd1], b0};
    case (sz)
      2'd0:    return sgn ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'd1:    return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: return {mem_model[a[9:0] + 10'd3], mem_model[a[9:0] + 10'd2], h};
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int n;
    n = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    for (int k = 0; k < n; k++) begin
      mem_model[a[9:0] + 10'(k)] = d[8*k +: 8];
    end
  endtask

  // One complete transaction on instance idx, including latency check,
  // optional response backpressure, and the closing handshake.
  task automatic do_txn(input int idx, input string tag, input logic wr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic exp_fault, input int hold);
    exp_t e;
    logic acc;
    int   guard;
    int   lat;
    req_valid[idx]     = 1'b1;
    req_wr_en[idx]     = wr;
    req_size[idx]      = sz;
    req_is_signed[idx] = sgn;
    req_addr[idx]      = a;
    req_wr_data[idx]   = wd;
    exp_q.push_back('{data: exp_data, fault: exp_fault});
    if (idx == 0 && wr && !exp_fault) begin
      model_store(a, sz, wd);
    end
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 20) begin
      acc = req_ready[idx];
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      check_vec({tag, "_accept_timeout"}, 32'd0, 32'd1);
    end
    // Keep a different request asserted; it must not be taken while busy.
    req_addr[idx]    = a ^ 32'h4;
    req_wr_en[idx]   = 1'b0;
    req_size[idx]    = 2'd2;
    lat = 1;
    while (!rsp_valid[idx] && lat < 20) begin
      check_vec({tag, "_busy_ready"}, {31'd0, req_ready[idx]}, 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check_vec({tag, "_latency"}, 32'(lat), 32'(wait_of(idx) + 1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_vec({tag, "_data"}, rsp_rd_data[idx], e.data);
      check_vec({tag, "_fault"}, {31'd0, rsp_fault[idx]}, {31'd0, e.fault});
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        check_vec({tag, "_hold_valid"}, {31'd0, rsp_valid[idx]}, 32'd1);
        check_vec({tag, "_hold_data"}, rsp_rd_data[idx], e.data);
        check_vec({tag, "_hold_ready"}, {31'd0, req_ready[idx]}, 32'd0);
      end
    end
    rsp_ready[idx] = 1'b1;
    req_valid[idx] = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready[idx] = 1'b0;
    check_vec({tag, "_done_valid"}, {31'd0, rsp_valid[idx]}, 32'd0);
    check_vec({tag, "_done_ready"}, {31'd0, req_ready[idx]}, 32'd1);
    $display("txn %s inst=%0d wr=%0d size=%0d addr=%08h lat=%0d", tag, idx, wr, sz, a, lat);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    logic        wr;
    logic        sgn;
    logic        flt;
    logic [31:0] d;
    logic        acc;
    int          guard;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0;
      req_valid[i] = 1'b0;
      req_addr[i] = 32'h0;
      req_wr_en[i] = 1'b0;
      req_size[i] = 2'd0;
      req_is_signed[i] = 1'b0;
      req_wr_data[i] = 32'h0;
      rsp_ready[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check_vec("reset_req_ready", {31'd0, req_ready[i]}, 32'd1);
      check_vec("reset_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
      check_vec("reset_rd_data", rsp_rd_data[i], 32'd0);
      check_vec("reset_fault", {31'd0, rsp_fault[i]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    @(posedge clk);
    #1;

    // Word store/load and sign extension, one wait state.
    do_txn(0, "st_w_10", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    do_txn(0, "ld_w_10", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    do_txn(0, "st_w_20", 1, 2'd2, 0, 32'h20, 32'h80FF7F01, 32'h0, 0, 0);
    do_txn(0, "ld_bs_22", 0, 2'd0, 1, 32'h22, 32'h0, 32'hFFFFFFFF, 0, 0);
    do_txn(0, "ld_bu_22", 0, 2'd0, 0, 32'h22, 32'h0, 32'h000000FF, 0, 0);
    do_txn(0, "ld_hs_22", 0, 2'd1, 1, 32'h22, 32'h0, 32'hFFFF80FF, 0, 0);
    do_txn(0, "ld_bs_20", 0, 2'd0, 1, 32'h20, 32'h0, 32'h00000001, 0, 0);
    do_txn(0, "st_b_21", 1, 2'd0, 0, 32'h21, 32'hFFFFFFAB, 32'h0, 0, 0);
    do_txn(0, "ld_w_20", 0, 2'd2, 0, 32'h20, 32'h0, 32'h80FFAB01, 0, 0);

    // Faults and range boundary.
    do_txn(0, "ld_h_11", 0, 2'd1, 1, 32'h11, 32'h0, 32'h0, 1, 0);
    do_txn(0, "st_w_3fc", 1, 2'd2, 0, 32'h3FC, 32'h11223344, 32'h0, 0, 0);
    do_txn(0, "st_w_3fe", 1, 2'd2, 0, 32'h3FE, 32'hCCCCCCCC, 32'h0, 1, 0);
    do_txn(0, "ld_w_3fc", 0, 2'd2, 0, 32'h3FC, 32'h0, 32'h11223344, 0, 0);
    do_txn(0, "st_h_3fe", 1, 2'd1, 0, 32'h3FE, 32'h5555BEEF, 32'h0, 0, 0);
    do_txn(0, "ld_hu_3fe", 0, 2'd1, 0, 32'h3FE, 32'h0, 32'h0000BEEF, 0, 0);
    do_txn(0, "ld_w_3fc2", 0, 2'd2, 0, 32'h3FC, 32'h0, 32'hBEEF3344, 0, 0);
    do_txn(0, "ld_b_400", 0, 2'd0, 0, 32'h400, 32'h0, 32'h0, 1, 0);
    do_txn(0, "ld_sz3", 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 0);
    do_txn(0, "st_sz3", 1, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 0);
    do_txn(0, "ld_w_10b", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 5);

    // Zero and three wait states with backpressure.
    do_txn(1, "w0_st", 1, 2'd2, 0, 32'h8, 32'hCAFEF00D, 32'h0, 0, 0);
    do_txn(1, "w0_ld", 0, 2'd2, 0, 32'h8, 32'h0, 32'hCAFEF00D, 0, 5);
    do_txn(1, "w0_ld_hs", 0, 2'd1, 1, 32'hA, 32'h0, 32'hFFFFCAFE, 0, 0);
    do_txn(2, "w3_st", 1, 2'd2, 0, 32'h8, 32'h01234567, 32'h0, 0, 0);
    do_txn(2, "w3_ld", 0, 2'd2, 0, 32'h8, 32'h0, 32'h01234567, 0, 5);
    do_txn(2, "w3_ld_bs", 0, 2'd0, 1, 32'h8, 32'h0, 32'h00000067, 0, 0);

    // Reset during WAIT discards the pending store.
    do_txn(0, "st_w_40", 1, 2'd2, 0, 32'h40, 32'h0, 32'h0, 0, 0);
    req_valid[0] = 1'b1;
    req_wr_en[0] = 1'b1;
    req_size[0] = 2'd2;
    req_addr[0] = 32'h40;
    req_wr_data[0] = 32'h12345678;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 20) begin
      acc = req_ready[0];
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check_vec("rst_accept_timeout", 32'd0, 32'd1);
    req_valid[0] = 1'b0;
    rst[0] = 1'b0;
    #1;
    check_vec("rst_wait_req_ready", {31'd0, req_ready[0]}, 32'd1);
    check_vec("rst_wait_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    $display("txn rst_during_wait inst=0 addr=00000040");
    do_txn(0, "ld_w_40", 0, 2'd2, 0, 32'h40, 32'h0, 32'h0, 0, 0);

    // Random traffic against the byte model.
    for (int k = 0; k < 16; k++) begin
      a = 32'h100 + 32'(4 * k);
      d = $urandom;
      do_txn(0, "rnd_init", 1, 2'd2, 0, a, d, 32'h0, 0, 0);
    end
    for (int k = 0; k < 24; k++) begin
      wr  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 2));
      sgn = 1'($urandom_range(0, 1));
      a   = 32'h100 + 32'($urandom_range(0, 60));
      d   = $urandom;
      flt = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
      do_txn(0, "rnd", wr, sz, sgn, a, d,
             (wr || flt) ? 32'h0 : model_load(a, sz, sgn), flt, k % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_dmem_ctrl.md
Name: rv_dmem_ctrl

Overview:
- Parametrised data-memory controller that replaces the fixed one-cycle data-memory path of the memory stage.
- Adds a valid/ready request/response handshake, a configurable wait-state latency, and byte/half/word access sizing with sign extension.
- Detects misaligned and out-of-range accesses and reports them as faults.
- Sits between the execute-stage address/store-data outputs and write-back; one transaction outstanding at a time.

Parameters:
- DMEM_SIZE_BYTES, 1024: array size in bytes; power of two, at least 4.
- ADDR_W, 32: request address width.
- WAIT_CYCLES, 1: wait states between acceptance and response; 0 is legal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_wr_en  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and faults.
- req_is_signed  in  1  sign-extend the load result; ignored for word and for stores.
- req_wr_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rd_data  out  32  load result, zero- or sign-extended; 0 for stores and faults.
- rsp_fault  out  1  access was misaligned, out of range, or had an illegal size.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; wait counter is cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rd_data=0, rsp_fault=0.
  - Array contents are not cleared.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture addr, wr_en, size, is_signed and wr_data. Go to WAIT if WAIT_CYCLES>0, otherwise straight to RESP. Load the counter with WAIT_CYCLES-1.
  - WAIT: req_ready=0. Decrement the counter each cycle; leave for RESP on the cycle the counter is 0.
  - RESP: rsp_valid=1. rsp_rd_data and rsp_fault are held stable until rsp_ready. On rsp_ready, go to IDLE.
- Latency: response becomes valid WAIT_CYCLES+1 edges after the acceptance edge. Peak throughput is one transaction per WAIT_CYCLES+2 cycles.
- req_ready is 0 in WAIT and RESP, including the cycle in which rsp_ready is sampled high. There is no same-cycle turnaround.
- Fault check, evaluated on the captured request:
  - half access with addr[0]!=0;
  - word access with addr[1:0]!=0;
  - size==3;
  - addr+access_bytes > DMEM_SIZE_BYTES.
- A faulted access does not write the array, and returns rsp_rd_data=0, rsp_fault=1.
- Commit timing: both the array write and the read sample happen on the edge that enters RESP.
  - Reset asserted during WAIT discards the pending store; the array is unchanged.
  - Reset during RESP drops the response with no further side effects.
- Storage is little-endian, byte-addressed, indexed by addr[log2(DMEM_SIZE_BYTES)-1:0].
  - Store byte: 1 lane written. Store half: 2 lanes. Store word: 4 lanes.
  - Load byte/half: selected lanes, zero-extended, or sign-extended from bit 7/15 when req_is_signed=1.
- req_valid asserted while req_ready=0 is ignored, and inputs are not sampled. The master must hold the request until accepted.
- All request fields are registered at acceptance. Input changes after acceptance have no effect.

Decomposition:
- Shared package rv_mem_pkg holds:
  - enum mem_size_t {SIZE_B=0, SIZE_H=1, SIZE_W=2};
  - enum dmem_state_t {IDLE, WAIT, RESP};
  - struct dmem_req_t {addr, wr_en, size, is_signed, wr_data};
  - a function align_load(word, offset, size, is_signed) returning the extended 32-bit result.
- Sub-module rv_dmem_array: byte-addressed storage with a 4-bit lane-enable write port and a synchronous word read. The controller instantiates it and owns the FSM, fault logic and lane steering.

Test Plan:
- WAIT_CYCLES=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid on the 2nd edge after acceptance, rd_data=0xDEADBEEF, fault=0.
- Byte/half sign extension: store word 0x80FF7F01 @0x20. Then:
  - load byte @0x22 signed -> 0xFFFFFFFF;
  - load byte @0x22 unsigned -> 0x000000FF;
  - load half @0x22 signed -> 0xFFFF80FF;
  - load byte @0x20 signed -> 0x00000001.
- Byte store: store byte 0xAB @0x21 over 0x80FF7F01 -> load word @0x20 returns 0x80FFAB01.
- Faults (none write the array):
  - load half @0x11 -> fault=1, rd_data=0;
  - store word @0x3FE, size 1024 -> fault=1, array unchanged;
  - size=3 -> fault=1.
- Backpressure and latency:
  - hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rd_data stable, req_ready=0, and a second req_valid is not accepted;
  - repeat with WAIT_CYCLES=0 (rsp_valid 1 edge after acceptance) and WAIT_CYCLES=3 (rsp_valid 4 edges after acceptance).
- Reset mid-operation: store 0x12345678 @0x40 over old 0x0, assert rst during WAIT -> req_ready=1 and rsp_valid=0 immediately; a subsequent load @0x40 returns 0x00000000.
